ahb_reg_slave: RTL and testbench

AHB_REG_SLAVE -- requirements
Module: ahb_reg_slave

---
 rtl/ahb_reg_slave_if.sv | 27 ++
 rtl/ahb_reg_slave.sv | 148 ++++++++++++++
 tb/tb_ahb_reg_slave.sv | 276 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/ahb_reg_slave_if.sv
// AHB-Lite slave bus bundle for ahb_reg_slave: address/control, write data,
// bus-wide HREADY and the slave response signals.
interface ahb_reg_slave_if #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 32
);
    logic                  HSEL;
    logic [ADDR_WIDTH-1:0] HADDR;
    logic [1:0]            HTRANS;
    logic                  HWRITE;
    logic [2:0]            HSIZE;
    logic [DATA_WIDTH-1:0] HWDATA;
    logic                  HREADY;
    logic [DATA_WIDTH-1:0] HRDATA;
    logic                  HRESP;
    logic                  HREADYOUT;

    modport master (
        output HSEL, HADDR, HTRANS, HWRITE, HSIZE, HWDATA, HREADY,
        input  HRDATA, HRESP, HREADYOUT
    );

    modport slave (
        input  HSEL, HADDR, HTRANS, HWRITE, HSIZE, HWDATA, HREADY,
        output HRDATA, HRESP, HREADYOUT
    );
endinterface

// File: rtl/ahb_reg_slave.sv
// AHB-Lite word register file with programmable wait states and two-cycle ERROR
// response. Define AHB_SLV_ERR_EN to flag addresses beyond the register window.
module ahb_reg_slave #(
    parameter int unsigned DATA_WIDTH  = 32,
    parameter int unsigned ADDR_WIDTH  = 32,
    parameter int unsigned NUM_REGS    = 16,
    parameter int unsigned WAIT_STATES = 1
) (
    input  logic           HCLK,
    input  logic           HRESET,
    ahb_reg_slave_if.slave ahb
);
    localparam int unsigned IDX_W = $clog2(NUM_REGS);

`ifdef AHB_SLV_ERR_EN
    localparam bit CHECK_HI = 1'b1;
`else
    localparam bit CHECK_HI = 1'b0;
`endif

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT,
        ST_DATA,
        ST_ERR1,
        ST_ERR2
    } state_t;

    state_t                state;
    logic [3:0]            wait_cnt;
    logic [IDX_W-1:0]      idx_q;
    logic [1:0]            lo_q;
    logic [1:0]            size_q;
    logic                  write_q;
    logic [DATA_WIDTH-1:0] regs [NUM_REGS];
    logic [DATA_WIDTH-1:0] hrdata_q;
    logic                  hresp_q;
    logic                  hreadyout_q;

    logic                  req;
    logic                  addr_valid;
    logic [IDX_W-1:0]      idx_d;
    logic [3:0]            be_q;
    logic [DATA_WIDTH-1:0] wr_merged;
    logic [DATA_WIDTH-1:0] rd_fwd;

    assign ahb.HRDATA    = hrdata_q;
    assign ahb.HRESP     = hresp_q;
    assign ahb.HREADYOUT = hreadyout_q;

    always_comb begin
        req   = ahb.HSEL && ahb.HREADY && (ahb.HTRANS == 2'b10 || ahb.HTRANS == 2'b11);
        idx_d = ahb.HADDR[IDX_W+1:2];

        addr_valid = 1'b1;
        case (ahb.HSIZE)
            3'b000:  addr_valid = 1'b1;
            3'b001:  addr_valid = !ahb.HADDR[0];
            3'b010:  addr_valid = (ahb.HADDR[1:0] == 2'b00);
            default: addr_valid = 1'b0;
        endcase
        if (CHECK_HI && (ahb.HADDR[ADDR_WIDTH-1:IDX_W+2] != '0))
            addr_valid = 1'b0;

        case (size_q)
            2'b00:   be_q = 4'b0001 << lo_q;
            2'b01:   be_q = lo_q[1] ? 4'b1100 : 4'b0011;
            default: be_q = 4'b1111;
        endcase

        wr_merged = regs[idx_q];
        for (int unsigned b = 0; b < 4; b++)
            if (be_q[b])
                wr_merged[8*b +: 8] = ahb.HWDATA[8*b +: 8];

        // A read pipelined behind a write to the same register sees the new value
        if (state == ST_DATA && write_q && idx_q == idx_d)
            rd_fwd = wr_merged;
        else
            rd_fwd = regs[idx_d];
    end

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            state       <= ST_IDLE;
            wait_cnt    <= '0;
            idx_q       <= '0;
            lo_q        <= '0;
            size_q      <= '0;
            write_q     <= 1'b0;
            hrdata_q    <= '0;
            hresp_q     <= 1'b0;
            hreadyout_q <= 1'b1;
            for (int unsigned i = 0; i < NUM_REGS; i++)
                regs[i] <= '0;
        end else begin
            if (state == ST_DATA && write_q)
                regs[idx_q] <= wr_merged;

            hrdata_q    <= '0;
            hresp_q     <= 1'b0;
            hreadyout_q <= 1'b1;

            case (state)
                ST_IDLE, ST_DATA: begin
                    if (req) begin
                        idx_q   <= idx_d;
                        lo_q    <= ahb.HADDR[1:0];
                        size_q  <= ahb.HSIZE[1:0];
                        write_q <= ahb.HWRITE;
                        if (!addr_valid) begin
                            state       <= ST_ERR1;
                            hresp_q     <= 1'b1;
                            hreadyout_q <= 1'b0;
                        end else if (WAIT_STATES == 0) begin
                            state <= ST_DATA;
                            if (!ahb.HWRITE)
                                hrdata_q <= rd_fwd;
                        end else begin
                            state       <= ST_WAIT;
                            wait_cnt    <= 4'(WAIT_STATES - 1);
                            hreadyout_q <= 1'b0;
                        end
                    end else begin
                        state <= ST_IDLE;
                    end
                end
                ST_WAIT: begin
                    if (wait_cnt == '0) begin
                        state <= ST_DATA;
                        if (!write_q)
                            hrdata_q <= regs[idx_q];
                    end else begin
                        wait_cnt    <= wait_cnt - 4'd1;
                        hreadyout_q <= 1'b0;
                    end
                end
                ST_ERR1: begin
                    state   <= ST_ERR2;
                    hresp_q <= 1'b1;
                end
                // Any address phase shown during ERR2 is dropped; the master cancels it
                ST_ERR2: state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_ahb_reg_slave.sv
// Randomized AHB-Lite master driving three register slaves (0, 1 and 3 wait
// states) against a transaction-level register-file model.
module tb_ahb_reg_slave;
    logic        HCLK = 1'b0;
    logic        HRESET;
    logic        hsel;
    logic [31:0] haddr;
    logic [1:0]  htrans;
    logic        hwrite;
    logic [2:0]  hsize;
    logic [31:0] hwdata;
    int          dsel;

    always #5 HCLK = ~HCLK;

    ahb_reg_slave_if #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) bus0 ();
    ahb_reg_slave_if #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) bus1 ();
    ahb_reg_slave_if #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) bus2 ();

    assign bus0.HSEL = hsel && (dsel == 0);
    assign bus1.HSEL = hsel && (dsel == 1);
    assign bus2.HSEL = hsel && (dsel == 2);
    assign bus0.HADDR = haddr;   assign bus1.HADDR = haddr;   assign bus2.HADDR = haddr;
    assign bus0.HTRANS = htrans; assign bus1.HTRANS = htrans; assign bus2.HTRANS = htrans;
    assign bus0.HWRITE = hwrite; assign bus1.HWRITE = hwrite; assign bus2.HWRITE = hwrite;
    assign bus0.HSIZE = hsize;   assign bus1.HSIZE = hsize;   assign bus2.HSIZE = hsize;
    assign bus0.HWDATA = hwdata; assign bus1.HWDATA = hwdata; assign bus2.HWDATA = hwdata;
    assign bus0.HREADY = bus0.HREADYOUT;
    assign bus1.HREADY = bus1.HREADYOUT;
    assign bus2.HREADY = bus2.HREADYOUT;

    ahb_reg_slave #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .NUM_REGS(16), .WAIT_STATES(0))
        dut0 (.HCLK(HCLK), .HRESET(HRESET), .ahb(bus0));
    ahb_reg_slave #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .NUM_REGS(16), .WAIT_STATES(1))
        dut1 (.HCLK(HCLK), .HRESET(HRESET), .ahb(bus1));
    ahb_reg_slave #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .NUM_REGS(16), .WAIT_STATES(3))
        dut2 (.HCLK(HCLK), .HRESET(HRESET), .ahb(bus2));

    logic [2:0]  rdy_v, resp_v;
    logic [31:0] rdata_v [3];
    assign rdy_v[0] = bus0.HREADYOUT; assign resp_v[0] = bus0.HRESP; assign rdata_v[0] = bus0.HRDATA;
    assign rdy_v[1] = bus1.HREADYOUT; assign resp_v[1] = bus1.HRESP; assign rdata_v[1] = bus1.HRDATA;
    assign rdy_v[2] = bus2.HREADYOUT; assign resp_v[2] = bus2.HRESP; assign rdata_v[2] = bus2.HRDATA;

    typedef struct {
        logic [31:0] addr;
        logic        write;
        logic [2:0]  size;
        logic [31:0] wdata;
    } txn_t;

    int          ws_of [3] = '{0, 1, 3};
    logic [31:0] model [3][16];
    txn_t        q [$];
    logic [31:0] last_rdata;
    int          checks = 0;
    int          failures = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s dut=%0d: got=%08h expected=%08h", tag, dsel, got, exp);
        end
    endtask

    function automatic bit legal(input logic [31:0] a, input logic [2:0] s);
        if (s > 3'd2) return 1'b0;
        if ((a % (32'd1 << s)) != 0) return 1'b0;
`ifdef AHB_SLV_ERR_EN
        if (a >= 32'd64) return 1'b0;
`endif
        return 1'b1;
    endfunction

    function automatic void model_write(input int d, input txn_t t);
        int          idx;
        int          lane;
        logic [31:0] w;
        idx = int'((t.addr / 4) % 16);
        w   = model[d][idx];
        for (int k = 0; k < (1 << t.size); k++) begin
            lane = int'(t.addr % 4) + k;
            w[8*lane +: 8] = t.wdata[8*lane +: 8];
        end
        model[d][idx] = w;
    endfunction

    task automatic push(input logic [31:0] a, input logic w, input logic [2:0] s, input logic [31:0] wd);
        txn_t t;
        t.addr = a; t.write = w; t.size = s; t.wdata = wd;
        q.push_back(t);
    endtask

    task automatic push_random(input int n);
        logic [31:0] a;
        logic [2:0]  s;
        for (int i = 0; i < n; i++) begin
            s = 3'($urandom_range(2));
            if ($urandom_range(19) == 0) s = 3'($urandom_range(7));
            a = 32'($urandom_range(63));
            if ($urandom_range(4) != 0) a = a & ~((32'd1 << s[1:0]) - 32'd1);
            if ($urandom_range(9) == 0) a = a + 32'h100 * 32'($urandom_range(1, 3));
            push(a, 1'($urandom_range(1)), s, $urandom);
        end
    endtask

    task automatic drive_idle();
        hsel   = 1'($urandom_range(1));
        htrans = hsel ? 2'($urandom_range(1)) : 2'($urandom_range(3));
        haddr  = $urandom;
        hwrite = 1'($urandom_range(1));
        hsize  = 3'($urandom_range(2));
    endtask

    task automatic drive_txn(input txn_t t);
        hsel   = 1'b1;
        htrans = $urandom_range(1) ? 2'b10 : 2'b11;
        haddr  = t.addr;
        hwrite = t.write;
        hsize  = t.size;
    endtask

    // Entered and left just after a rising edge; drains q through slave d.
    task automatic run(input int d, input int gap_pct);
        txn_t        a, dp;
        bit          a_v = 1'b0, d_v = 1'b0, ign = 1'b0, e1 = 1'b0, ok;
        int          low = 0, budget = 0;
        logic        rdy, resp;
        logic [31:0] rdata;
        dsel = d;
        if (q.size() > 0 && $urandom_range(99) >= gap_pct) begin
            a = q.pop_front(); a_v = 1'b1; drive_txn(a);
        end else drive_idle();
        forever begin
            @(negedge HCLK);
            rdy = rdy_v[d]; resp = resp_v[d]; rdata = rdata_v[d];
            ign = 1'b0;
            if (d_v) begin
                ok = legal(dp.addr, dp.size);
                if (!rdy) begin
                    if (resp) e1 = 1'b1;
                    else low++;
                    check("wait_rdata", rdata, 32'd0);
                end else begin
                    check("resp", 32'(resp), 32'(!ok));
                    check("wait_low", 32'(low), ok ? 32'(ws_of[d]) : 32'd0);
                    check("err1_seen", 32'(e1), 32'(!ok));
                    if (ok && !dp.write) begin
                        check("rdata", rdata, model[d][(dp.addr / 4) % 16]);
                        last_rdata = rdata;
                    end else if (ok) model_write(d, dp);
                    else check("err_rdata", rdata, 32'd0);
                    ign = resp;
                    d_v = 1'b0;
                end
            end else begin
                check("idle_rdy", 32'(rdy), 32'd1);
                check("idle_resp", 32'(resp), 32'd0);
                check("idle_rdata", rdata, 32'd0);
            end
            budget++;
            if (budget > 3000) begin
                check("timeout", 32'd0, 32'd1);
                q.delete();
                break;
            end
            if (!d_v && !a_v && q.size() == 0) break;
            @(posedge HCLK); #1;
            if (rdy) begin
                if (a_v && !ign) begin
                    dp = a; d_v = 1'b1; low = 0; e1 = 1'b0; a_v = 1'b0;
                end
                if (!a_v && q.size() > 0 && $urandom_range(99) >= gap_pct) begin
                    a = q.pop_front(); a_v = 1'b1;
                end
                if (a_v) drive_txn(a);
                else drive_idle();
                hwdata = d_v ? dp.wdata : $urandom;
            end
        end
        @(posedge HCLK); #1;
        hsel = 1'b0; htrans = 2'b00;
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [31:0] exp27;
        HRESET = 1'b1; hsel = 1'b0; htrans = 2'b00; haddr = '0;
        hwrite = 1'b0; hsize = 3'd2; hwdata = '0; dsel = 0; last_rdata = '0;
        for (int d = 0; d < 3; d++)
            for (int r = 0; r < 16; r++) model[d][r] = '0;
        repeat (3) @(posedge HCLK);
        @(negedge HCLK);
        for (int d = 0; d < 3; d++) begin
            dsel = d;
            check("rst_rdy", 32'(rdy_v[d]), 32'd1);
            check("rst_resp", 32'(resp_v[d]), 32'd0);
            check("rst_rdata", rdata_v[d], 32'd0);
        end
        @(posedge HCLK); #1;
        HRESET = 1'b0;
        @(posedge HCLK); #1;

        push(32'h08, 1'b1, 3'd2, 32'hDEADBEEF);
        push(32'h08, 1'b0, 3'd2, 32'h0);
        run(1, 0);
        check("wr_rd_08", last_rdata, 32'hDEADBEEF);

        push(32'h0C, 1'b1, 3'd2, 32'h11223344);
        push(32'h0D, 1'b1, 3'd0, 32'hAAAAAAAA);
        push(32'h0C, 1'b0, 3'd2, 32'h0);
        run(1, 0);
        check("byte_lane_0D", last_rdata, 32'h1122AA44);

        push(32'h04, 1'b1, 3'd2, 32'hCAFEF00D);
        push(32'h04, 1'b0, 3'd2, 32'h0);
        run(0, 0);
        check("zero_wait_b2b", last_rdata, 32'hCAFEF00D);

        push(32'h06, 1'b0, 3'd2, 32'h0);
        push(32'h06, 1'b1, 3'd2, 32'h0BADF00D);
        push(32'h08, 1'b0, 3'd2, 32'h0);
        run(1, 0);
        check("err_no_modify", last_rdata, 32'hDEADBEEF);

        push(32'h100, 1'b1, 3'd2, 32'h5A5A5A5A);
        push(32'h00, 1'b0, 3'd2, 32'h0);
        run(1, 0);
`ifdef AHB_SLV_ERR_EN
        exp27 = 32'h0;
`else
        exp27 = 32'h5A5A5A5A;
`endif
        check("out_of_range_0x100", last_rdata, exp27);

        for (int d = 0; d < 3; d++) begin
            push_random(80);
            run(d, 30);
            push_random(60);
            run(d, 0);
        end

        for (int r = 0; r < 16; r++) push(32'(4 * r), 1'b1, 3'd2, $urandom | 32'h1);
        run(2, 0);
        dsel = 2;
        hsel = 1'b1; htrans = 2'b10; haddr = 32'h10; hwrite = 1'b1; hsize = 3'd2;
        @(posedge HCLK); #1;
        hsel = 1'b0; htrans = 2'b00; hwdata = 32'h12345678;
        @(negedge HCLK);
        check("ws3_in_wait", 32'(rdy_v[2]), 32'd0);
        @(posedge HCLK); #1;
        HRESET = 1'b1;
        @(posedge HCLK); #1;
        HRESET = 1'b0;
        @(negedge HCLK);
        check("rst_wait_rdy", 32'(rdy_v[2]), 32'd1);
        check("rst_wait_resp", 32'(resp_v[2]), 32'd0);
        check("rst_wait_rdata", rdata_v[2], 32'd0);
        for (int d = 0; d < 3; d++)
            for (int r = 0; r < 16; r++) model[d][r] = '0;
        @(posedge HCLK); #1;
        last_rdata = 32'hFFFFFFFF;
        for (int r = 0; r < 16; r++) push(32'(4 * r), 1'b0, 3'd2, 32'h0);
        run(2, 0);
        check("rst_wait_last_reg", last_rdata, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
